// File: rtl/ysyx_041514_div_ctrl_if.sv
// rtl/ysyx_041514_div_ctrl_if.sv - request/response and divider handshake bundle
// slave is the controller; master is the pipeline plus divider side.
interface ysyx_041514_div_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;
  logic            div_valid_o;
  logic            div_signed_o;
  logic            div32_o;
  logic [XLEN-1:0] div_dividend_o;
  logic [XLEN-1:0] div_divisor_o;
  logic            div_ready_i;
  logic [XLEN-1:0] div_quot_i;
  logic [XLEN-1:0] div_rem_i;

  modport slave (
    input  req_valid_i, req_op_i, rs1_i, rs2_i, flush_i, resp_ready_i,
    input  div_ready_i, div_quot_i, div_rem_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output div_valid_o, div_signed_o, div32_o, div_dividend_o, div_divisor_o
  );

  modport master (
    output req_valid_i, req_op_i, rs1_i, rs2_i, flush_i, resp_ready_i,
    output div_ready_i, div_quot_i, div_rem_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  div_valid_o, div_signed_o, div32_o, div_dividend_o, div_divisor_o
  );
endinterface

// File: rtl/ysyx_041514_div_ctrl.sv
// rtl/ysyx_041514_div_ctrl.sv - divide/remainder sequencer with bypass and one-entry result cache
// Special cases and cache hits answer in one cycle; everything else goes through the external divider.
module ysyx_041514_div_ctrl #(
  parameter int XLEN = 64
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_041514_div_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_RST, S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;

  state_t          state, next_state;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_q, rs2_q, data_q;

  logic            cache_valid, cache_uns, cache_word;
  logic [XLEN-1:0] cache_rs1, cache_rs2, cache_quot, cache_rem;

  logic            accept, word, uns, div_zero, overflow, bypass, hit, finish;
  logic [XLEN-1:0] byp_quot, byp_rem, fast_data;

  // Select quotient/remainder and fold word results back to a sign-extended 64-bit value.
  function automatic logic [XLEN-1:0] pick(input logic [2:0] o, input logic [XLEN-1:0] q,
                                           input logic [XLEN-1:0] r);
    logic [XLEN-1:0] v;
    v = o[2] ? r : q;
    if (o[1]) v = {{(XLEN-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  always_comb begin
    word     = bus.req_op_i[1];
    uns      = bus.req_op_i[0];
    div_zero = word ? (bus.rs2_i[31:0] == 32'h0) : (bus.rs2_i == '0);
    overflow = ~uns & (word ? (bus.rs1_i[31:0] == 32'h8000_0000 && bus.rs2_i[31:0] == 32'hFFFF_FFFF)
                            : (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2_i == '1));
    bypass   = div_zero | overflow;
    byp_quot = div_zero ? '1 : bus.rs1_i;
    byp_rem  = div_zero ? bus.rs1_i : '0;
    hit      = cache_valid && bus.rs1_i == cache_rs1 && bus.rs2_i == cache_rs2 &&
               uns == cache_uns && word == cache_word;
    fast_data = bypass ? pick(bus.req_op_i, byp_quot, byp_rem)
                       : pick(bus.req_op_i, cache_quot, cache_rem);
    accept   = (state == S_IDLE) & ~bus.flush_i & bus.req_valid_i;
    finish   = (state == S_WAIT) & ~bus.flush_i & bus.div_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RST;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RST:   next_state = S_IDLE;
      S_IDLE:  if (accept) next_state = (bypass | hit) ? S_RESP : S_ISSUE;
      S_ISSUE: next_state = bus.flush_i ? S_IDLE : S_WAIT;
      S_WAIT:  if (bus.flush_i) next_state = S_DRAIN;
               else if (bus.div_ready_i) next_state = S_RESP;
      S_DRAIN: if (bus.div_ready_i) next_state = S_IDLE;
      S_RESP:  if (bus.flush_i || bus.resp_ready_i) next_state = S_IDLE;
      default: next_state = S_RST;
    endcase
  end

  // Divider-facing fields are forced to zero whenever no divider operation belongs to us.
  always_comb begin
    bus.req_ready_o    = (state == S_IDLE) & ~bus.flush_i;
    bus.resp_valid_o   = (state == S_RESP);
    bus.resp_data_o    = (state == S_RESP) ? data_q : '0;
    bus.div_valid_o    = (state == S_ISSUE) & ~bus.flush_i;
    bus.div_signed_o   = 1'b0;
    bus.div32_o        = 1'b0;
    bus.div_dividend_o = '0;
    bus.div_divisor_o  = '0;
    if (state == S_ISSUE || state == S_WAIT || state == S_DRAIN) begin
      bus.div_signed_o   = ~op[0];
      bus.div32_o        = op[1];
      bus.div_dividend_o = rs1_q;
      bus.div_divisor_o  = rs2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= 3'b000;
      rs1_q       <= '0;
      rs2_q       <= '0;
      data_q      <= '0;
      cache_valid <= 1'b0;
      cache_uns   <= 1'b0;
      cache_word  <= 1'b0;
      cache_rs1   <= '0;
      cache_rs2   <= '0;
      cache_quot  <= '0;
      cache_rem   <= '0;
    end else begin
      if (accept) begin
        op    <= bus.req_op_i;
        rs1_q <= bus.rs1_i;
        rs2_q <= bus.rs2_i;
        if (bypass | hit) data_q <= fast_data;
      end
      if (finish) begin
        data_q      <= pick(op, bus.div_quot_i, bus.div_rem_i);
        cache_valid <= 1'b1;
        cache_uns   <= op[0];
        cache_word  <= op[1];
        cache_rs1   <= rs1_q;
        cache_rs2   <= rs2_q;
        cache_quot  <= bus.div_quot_i;
        cache_rem   <= bus.div_rem_i;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_041514_div_ctrl.sv
// tb/tb_ysyx_041514_div_ctrl.sv - directed vector bench with a behavioural fixed-latency divider
// Expected results are hand-computed constants; the divider model only supplies raw quotient/remainder.
module tb_ysyx_041514_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_041514_div_ctrl_if #(.XLEN(64)) bus ();
  ysyx_041514_div_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Divider model: 3-cycle latency, ignores rst so stale completions can reach the controller.
  logic        busy = 1'b0, prev_valid = 1'b0, overlap_err = 1'b0;
  int          cnt = 0;
  logic [63:0] ma = '0, mb = '0;
  logic        msg = 1'b0, m32 = 1'b0;

  function automatic logic [63:0] mdiv(input logic [63:0] a, input logic [63:0] b,
                                       input logic sg, input logic w, input logic want_rem);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (sg && want_rem)  r32 = $signed(a32) % $signed(b32);
      else if (sg)         r32 = $signed(a32) / $signed(b32);
      else if (want_rem)   r32 = a32 % b32;
      else                 r32 = a32 / b32;
      return {32'h0, r32};
    end
    if (sg && want_rem)  r64 = $signed(a) % $signed(b);
    else if (sg)         r64 = $signed(a) / $signed(b);
    else if (want_rem)   r64 = a % b;
    else                 r64 = a / b;
    return r64;
  endfunction

  initial begin
    bus.div_ready_i = 1'b0;
    bus.div_quot_i  = '0;
    bus.div_rem_i   = '0;
  end

  always @(posedge clk) begin
    bus.div_ready_i <= 1'b0;
    prev_valid      <= (bus.div_valid_o === 1'b1);
    if (bus.div_valid_o === 1'b1) begin
      if (busy || prev_valid) overlap_err <= 1'b1;
      busy <= 1'b1;
      cnt  <= 3;
      ma   <= bus.div_dividend_o;
      mb   <= bus.div_divisor_o;
      msg  <= bus.div_signed_o;
      m32  <= bus.div32_o;
    end else if (busy) begin
      if (cnt == 1) begin
        busy            <= 1'b0;
        bus.div_ready_i <= 1'b1;
        bus.div_quot_i  <= mdiv(ma, mb, msg, m32, 1'b0);
        bus.div_rem_i   <= mdiv(ma, mb, msg, m32, 1'b1);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.req_ready_o, bus.resp_valid_o, bus.resp_data_o, bus.div_valid_o,
             bus.div_signed_o, bus.div32_o, bus.div_dividend_o, bus.div_divisor_o};
  endfunction

  // Called on a falling edge; returns on a falling edge with the controller back in IDLE.
  task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int stall, output logic [63:0] data, output int pulses,
                        output int lat);
    int n = 0;
    pulses = 0;
    lat    = 0;
    data   = '0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.rs1_i       = a;
    bus.rs2_i       = b;
    while (bus.req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 64'(n), 64'd0);
      bus.req_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (bus.resp_valid_o !== 1'b1 && lat < 100) begin
      if (bus.div_valid_o === 1'b1) pulses++;
      @(negedge clk);
      lat++;
    end
    data = bus.resp_data_o;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", s), 64'(bus.resp_valid_o), 64'd1);
      chk($sformatf("stall%0d_data", s), bus.resp_data_o, data);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] exp;
    int          pulses;
  } vec_t;

  vec_t        vecs[14];
  logic [63:0] d;
  int          p, l, n;
  logic        bad;

  initial begin
    vecs[0]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1};
    vecs[1]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[2]  = '{3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[3]  = '{3'b101, 64'd5, 64'd0, 64'd5, 0};
    vecs[4]  = '{3'b010, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
    vecs[5]  = '{3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0};
    vecs[6]  = '{3'b011, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1};
    vecs[7]  = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    vecs[8]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0};
    vecs[9]  = '{3'b111, 64'd7, 64'h0000_0001_0000_0000, 64'd7, 0};
    vecs[10] = '{3'b010, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 1};
    vecs[11] = '{3'b110, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 64'd2, 0};
    vecs[12] = '{3'b001, 64'd100, 64'd7, 64'd14, 1};
    vecs[13] = '{3'b111, 64'h8000_0005, 64'h10, 64'd5, 1};

    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 3'b000;
    bus.rs1_i        = '0;
    bus.rs2_i        = '0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_outputs_zero", 64'(any_out()), 64'd0);
    rst = 1'b0;
    chk("rst_cycle_ready_low", 64'(bus.req_ready_o), 64'd0);
    @(negedge clk);
    chk("idle_ready_high", 64'(bus.req_ready_o), 64'd1);

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].op, vecs[i].rs1, vecs[i].rs2, 0, d, p, l);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_pulses", i), 64'(p), 64'(vecs[i].pulses));
      if (vecs[i].pulses == 0) chk($sformatf("vec%0d_latency", i), 64'(l), 64'd1);
    end

    // Flush while in ISSUE: no divider start, straight back to IDLE.
    bus.req_valid_i = 1'b1; bus.req_op_i = 3'b001; bus.rs1_i = 64'd300; bus.rs2_i = 64'd7;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.flush_i = 1'b1;
    #1;
    chk("issue_flush_no_pulse", 64'(bus.div_valid_o), 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("issue_flush_idle", 64'({bus.req_ready_o, bus.resp_valid_o}), 64'b10);

    // Flush while in WAIT: DRAIN until the divider finishes, nothing returned or cached.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = 3'b001; bus.rs1_i = 64'd200; bus.rs2_i = 64'd7;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("wait_flush_issue_pulse", 64'(bus.div_valid_o), 64'd1);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bad = 1'b0;
    n = 0;
    while (bus.div_ready_i !== 1'b1 && n < 20) begin
      if (bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("drain_div_ready_seen", 64'(n < 20), 64'd1);
    chk("drain_ready_low", 64'({bad, bus.req_ready_o, bus.resp_valid_o}), 64'd0);
    @(negedge clk);
    chk("drain_exit_idle", 64'({bus.req_ready_o, bus.resp_valid_o}), 64'b10);
    do_req(3'b001, 64'd200, 64'd7, 0, d, p, l);
    chk("after_drain_data", d, 64'd28);
    chk("after_drain_miss", 64'(p), 64'd1);

    // Response stall: cache hit held for ten cycles.
    do_req(3'b001, 64'd200, 64'd7, 10, d, p, l);
    chk("stall_data", d, 64'd28);
    chk("stall_hit_latency", 64'(l), 64'd1);

    // Flush while in RESP drops the response.
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("resp_flush_valid_before", 64'(bus.resp_valid_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("resp_flush_dropped", 64'({bus.req_ready_o, bus.resp_valid_o}), 64'b10);

    // Reset in WAIT: outputs zero, stale completion ignored, cache emptied.
    @(negedge clk);
    do_req(3'b001, 64'd1000, 64'd10, 0, d, p, l);
    chk("pre_rst_data", d, 64'd100);
    bus.req_valid_i = 1'b1; bus.req_op_i = 3'b000; bus.rs1_i = 64'h64; bus.rs2_i = 64'd3;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wait_rst_outputs_zero", 64'(any_out()), 64'd0);
    rst = 1'b0;
    chk("wait_rst_ready_low", 64'(bus.req_ready_o), 64'd0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid_o !== 1'b0 || bus.div_valid_o !== 1'b0) bad = 1'b1;
    end
    chk("stale_div_ready_ignored", 64'(bad), 64'd0);
    do_req(3'b001, 64'd1000, 64'd10, 0, d, p, l);
    chk("post_rst_data", d, 64'd100);
    chk("post_rst_cache_empty", 64'(p), 64'd1);

    chk("div_valid_no_overlap", 64'(overlap_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
